// File: rtl/sram_arb_ctrl.sv
// Two-port arbiter and access sequencer for a 256Kx16 asynchronous SRAM.
// Each 32-bit access runs as a low-half phase then a high-half phase; m0 reads only, m1 reads or writes.
module sram_arb_ctrl #(
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter bit RR_EN   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic [18:0] i_m0_addr,
  output logic        o_m0_ack,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [18:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_strb,
  output logic        o_m1_ack,
  output logic [31:0] o_m1_rdata,
  output logic        o_busy,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

  localparam logic [7:0] RD_LAST = 8'(RD_WAIT);
  localparam logic [7:0] WR_LAST = 8'(WR_WAIT);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        last_m1;
  logic        sel_m1;
  logic        we;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [15:0] rd_lo;

  logic        grant_m1;
  logic        we_req;
  logic [3:0]  strb_req;
  logic        in_phase;
  logic        half;
  logic        phase_last;
  logic        unused_addr;

  assign unused_addr = ^{i_m0_addr[1:0], i_m1_addr[1:0]};

  // Arbitration: a tie goes to the port not granted last, or always to m1 when RR is off.
  always_comb begin
    grant_m1 = i_m1_req;
    if (i_m0_req && i_m1_req)
      grant_m1 = RR_EN ? !last_m1 : 1'b1;
    we_req   = grant_m1 && i_m1_we;
    strb_req = grant_m1 ? i_m1_strb : 4'hF;
  end

  assign in_phase   = (state == LO) || (state == HI);
  assign half       = (state == HI);
  assign phase_last = (cnt == (we ? WR_LAST : RD_LAST));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_m0_req || i_m1_req) begin
        if (we_req && strb_req[1:0] == 2'b00)
          state_nx = (strb_req[3:2] == 2'b00) ? ACK : HI;
        else
          state_nx = LO;
      end
      LO:   if (phase_last) state_nx = (we && strb[3:2] == 2'b00) ? ACK : HI;
      HI:   if (phase_last) state_nx = ACK;
      ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_m1    <= 1'b0;
      o_m0_rdata <= 32'd0;
      o_m1_rdata <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
      if (state == ACK)
        last_m1 <= sel_m1;
      if (state == HI && phase_last && !we) begin
        if (sel_m1) o_m1_rdata <= {SRAM_DQ, rd_lo};
        else        o_m0_rdata <= {SRAM_DQ, rd_lo};
      end
    end
  end

  // Transaction context is captured every IDLE cycle so the granting edge latches it.
  always_ff @(posedge i_clk) begin
    if (state == IDLE) begin
      sel_m1 <= grant_m1;
      we     <= we_req;
      word   <= grant_m1 ? i_m1_addr[18:2] : i_m0_addr[18:2];
      wdata  <= i_m1_wdata;
      strb   <= strb_req;
    end
    if (state == LO && phase_last)
      rd_lo <= SRAM_DQ;
  end

  // First cycle of a write phase is address setup; WE_N falls afterwards.
  always_comb begin
    SRAM_CE_N = !in_phase;
    SRAM_OE_N = !(in_phase && !we);
    SRAM_WE_N = !(in_phase && we && cnt != 8'd0);
    SRAM_LB_N = 1'b1;
    SRAM_UB_N = 1'b1;
    if (in_phase) begin
      SRAM_LB_N = we ? !(half ? strb[2] : strb[0]) : 1'b0;
      SRAM_UB_N = we ? !(half ? strb[3] : strb[1]) : 1'b0;
    end
    SRAM_ADDR = in_phase ? {word, half} : 18'd0;
  end

  assign SRAM_DQ  = (in_phase && we) ? (half ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;
  assign o_m0_ack = (state == ACK) && !sel_m1;
  assign o_m1_ack = (state == ACK) && sel_m1;
  assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: behavioural SRAM model plus expected-result queue per transaction.
module tb_sram_arb_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, m0_req, m0_ack, m1_req, m1_we, m1_ack, busy;
  logic [18:0] m0_addr, m1_addr;
  logic [31:0] m0_rdata, m1_rdata, m1_wdata;
  logic [3:0]  m1_strb;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  logic        b_m0_req, b_m0_ack, b_m1_req, b_m1_ack, b_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic [17:0] b_addr;
  wire  [15:0] b_dq;
  logic        b_ce_n, b_oe_n, b_we_n, b_lb_n, b_ub_n;

  sram_arb_ctrl #(.RD_WAIT(1), .WR_WAIT(1), .RR_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .o_m0_ack(m0_ack), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_strb(m1_strb), .o_m1_ack(m1_ack), .o_m1_rdata(m1_rdata), .o_busy(busy),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n));

  sram_arb_ctrl #(.RD_WAIT(1), .WR_WAIT(1), .RR_EN(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(b_m0_req), .i_m0_addr(19'h00010), .o_m0_ack(b_m0_ack), .o_m0_rdata(b_m0_rdata),
    .i_m1_req(b_m1_req), .i_m1_we(1'b1), .i_m1_addr(19'h00020), .i_m1_wdata(32'hA5A5A5A5),
    .i_m1_strb(4'hF), .o_m1_ack(b_m1_ack), .o_m1_rdata(b_m1_rdata), .o_busy(b_busy),
    .SRAM_ADDR(b_addr), .SRAM_DQ(b_dq), .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n),
    .SRAM_WE_N(b_we_n), .SRAM_LB_N(b_lb_n), .SRAM_UB_N(b_ub_n));

  logic [15:0] mem [0:262143];
  int we_low = 0;
  int ub_wr  = 0;

  assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      we_low = we_low + 1;
      if (!ub_n) ub_wr = ub_wr + 1;
      if (!lb_n) mem[sram_addr][7:0]  = sram_dq[7:0];
      if (!ub_n) mem[sram_addr][15:8] = sram_dq[15:8];
    end
  end

  typedef struct packed {logic port; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  logic        g_port;
  logic [31:0] g_data;
  int          g_lat;
  bit          g_ok;
  logic [31:0] m1_exp;

  task automatic wait_any(output logic port, output logic [31:0] data, output int lat, output bit ok);
    ok = 0; lat = 0; port = 1'b0; data = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        ok = 1; port = m1_ack; data = m1_ack ? m1_rdata : m0_rdata;
        break;
      end
      lat++;
    end
  endtask

  task automatic issue_m1(input logic w, input logic [18:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    m1_we = w; m1_addr = a; m1_wdata = d; m1_strb = s; m1_req = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; m0_req = 0; m1_req = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m1_wdata = 0; m1_strb = 0;
    b_m0_req = 0; b_m1_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b want 000", {m0_ack, m1_ack, busy}); end
    checks++; if (m0_rdata !== 32'd0) begin errors++; $display("FAIL reset_m0_rdata got %h want 0", m0_rdata); end
    checks++; if (m1_rdata !== 32'd0) begin errors++; $display("FAIL reset_m1_rdata got %h want 0", m1_rdata); end
    checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin errors++; $display("FAIL reset_pins got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n}); end
    checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    @(posedge clk); #1 rst = 1'b0;
    m1_exp = 32'd0;
  endtask

  task automatic test_m0_read;
    mem[18'h8] = 16'hBEEF; mem[18'h9] = 16'hDEAD;
    @(posedge clk); #1;
    m0_addr = 19'h00010; m0_req = 1'b1;
    sb.push_back('{1'b0, 32'hDEADBEEF});
    wait_any(g_port, g_data, g_lat, g_ok);
    m0_req = 1'b0;
    checks++; if (!g_ok) begin errors++; $display("FAIL m0_read_timeout got none want ack"); end
    checks++; if (g_lat != 5) begin errors++; $display("FAIL m0_read_latency got %0d want 5", g_lat); end
    e = sb.pop_front();
    checks++; if (g_port !== e.port || g_data !== e.data) begin errors++; $display("FAIL m0_read_sb got %0d/%h want %0d/%h", g_port, g_data, e.port, e.data); end
  endtask

  task automatic test_m1_write;
    mem[18'h10] = 16'hFFFF; mem[18'h11] = 16'hFFFF; we_low = 0;
    sb.push_back('{1'b1, m1_exp});
    issue_m1(1'b1, 19'h00020, 32'h12345678, 4'hF);
    wait_any(g_port, g_data, g_lat, g_ok);
    m1_req = 1'b0;
    checks++; if (g_lat != 5) begin errors++; $display("FAIL wr_latency got %0d want 5", g_lat); end
    e = sb.pop_front();
    checks++; if (g_port !== e.port || g_data !== e.data) begin errors++; $display("FAIL wr_sb got %0d/%h want %0d/%h", g_port, g_data, e.port, e.data); end
    checks++; if (mem[18'h10] !== 16'h5678) begin errors++; $display("FAIL wr_lo got %h want 5678", mem[18'h10]); end
    checks++; if (mem[18'h11] !== 16'h1234) begin errors++; $display("FAIL wr_hi got %h want 1234", mem[18'h11]); end
    checks++; if (we_low != 2) begin errors++; $display("FAIL wr_we_cycles got %0d want 2", we_low); end
  endtask

  task automatic test_strobes;
    mem[18'h20] = 16'h1111; mem[18'h21] = 16'h2222; we_low = 0; ub_wr = 0;
    sb.push_back('{1'b1, m1_exp});
    issue_m1(1'b1, 19'h00040, 32'hAB0000CC, 4'b0100);
    wait_any(g_port, g_data, g_lat, g_ok);
    m1_req = 1'b0;
    checks++; if (g_lat != 3) begin errors++; $display("FAIL strb_latency got %0d want 3", g_lat); end
    e = sb.pop_front();
    checks++; if (g_port !== e.port || g_data !== e.data) begin errors++; $display("FAIL strb_sb got %0d/%h want %0d/%h", g_port, g_data, e.port, e.data); end
    checks++; if (mem[18'h20] !== 16'h1111) begin errors++; $display("FAIL strb_lo got %h want 1111", mem[18'h20]); end
    checks++; if (mem[18'h21] !== 16'h2200) begin errors++; $display("FAIL strb_hi got %h want 2200", mem[18'h21]); end
    checks++; if (we_low != 1 || ub_wr != 0) begin errors++; $display("FAIL strb_pins got we%0d ub%0d want we1 ub0", we_low, ub_wr); end
    sb.push_back('{1'b1, m1_exp});
    issue_m1(1'b1, 19'h00040, 32'hFFFFFFFF, 4'b0000);
    wait_any(g_port, g_data, g_lat, g_ok);
    m1_req = 1'b0;
    checks++; if (g_lat != 1) begin errors++; $display("FAIL strb0_latency got %0d want 1", g_lat); end
    e = sb.pop_front();
    checks++; if (g_port !== e.port || g_data !== e.data) begin errors++; $display("FAIL strb0_sb got %0d/%h want %0d/%h", g_port, g_data, e.port, e.data); end
    checks++; if (mem[18'h21] !== 16'h2200 || we_low != 1) begin errors++; $display("FAIL strb0_nowrite got %h/%0d want 2200/1", mem[18'h21], we_low); end
    mem[18'h60] = 16'hC0DE; mem[18'h61] = 16'hFACE;
    m1_exp = 32'hFACEC0DE;
    sb.push_back('{1'b1, m1_exp});
    issue_m1(1'b0, 19'h000C0, 32'd0, 4'd0);
    wait_any(g_port, g_data, g_lat, g_ok);
    m1_req = 1'b0;
    e = sb.pop_front();
    checks++; if (g_lat != 5 || g_port !== e.port || g_data !== e.data) begin errors++; $display("FAIL m1_read got %0d/%h lat %0d want %0d/%h lat 5", g_port, g_data, g_lat, e.port, e.data); end
  endtask

  task automatic test_round_robin;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mem[18'h80] = 16'h0101; mem[18'h81] = 16'h0202;
    mem[18'h90] = 16'h0303; mem[18'h91] = 16'h0404;
    m1_exp = 32'h04040303;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b1, m1_exp});
      sb.push_back('{1'b0, 32'h02020101});
    end
    m0_addr = 19'h00100; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = 19'h00120; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_any(g_port, g_data, g_lat, g_ok);
      e = sb.pop_front();
      checks++; if (!g_ok || g_port !== e.port || g_data !== e.data) begin errors++; $display("FAIL rr_grant%0d got %0d/%h want %0d/%h", i, g_port, g_data, e.port, e.data); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_fixed_prio;
    bit got;
    logic bp;
    @(posedge clk); #1;
    b_m0_req = 1'b1; b_m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = 0; bp = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (b_m0_ack || b_m1_ack) begin got = 1; bp = b_m1_ack; break; end
      end
      if (i == 2) b_m1_req = 1'b0;
      checks++;
      if (!got || bp !== (i < 3)) begin errors++; $display("FAIL fixed_grant%0d got %0d/%0d want %0d", i, got, bp, (i < 3)); end
    end
    b_m0_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit seen, acked;
    mem[18'h28] = 16'h0000; mem[18'h29] = 16'h0000;
    issue_m1(1'b1, 19'h00050, 32'h12345678, 4'hF);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ce_n && sram_addr[0]) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_hi got none want HI phase"); end
    rst = 1'b1; m1_req = 1'b0;
    @(negedge clk);
    checks++; if ({ce_n, oe_n, we_n, lb_n, ub_n, busy, m1_ack} !== 7'b1111100) begin errors++; $display("FAIL rstmid_pins got %b want 1111100", {ce_n, oe_n, we_n, lb_n, ub_n, busy, m1_ack}); end
    @(posedge clk); #1 rst = 1'b0;
    acked = 0;
    repeat (8) begin @(negedge clk); if (m0_ack || m1_ack) acked = 1; end
    checks++; if (acked) begin errors++; $display("FAIL rstmid_ack got 1 want 0"); end
    checks++; if (mem[18'h28] !== 16'h5678 || mem[18'h29] !== 16'h0000) begin errors++; $display("FAIL rstmid_mem got %h/%h want 5678/0000", mem[18'h28], mem[18'h29]); end
    m1_exp = 32'd0;
    checks++; if (m1_rdata !== m1_exp) begin errors++; $display("FAIL rstmid_rdata got %h want %h", m1_rdata, m1_exp); end
  endtask

  task automatic test_back_to_back;
    mem[18'hA0] = 16'h3333; mem[18'hA1] = 16'h4444;
    mem[18'hB0] = 16'h5555; mem[18'hB1] = 16'h6666;
    sb.push_back('{1'b0, 32'h44443333});
    sb.push_back('{1'b0, 32'h66665555});
    @(posedge clk); #1;
    m0_addr = 19'h00143; m0_req = 1'b1;
    wait_any(g_port, g_data, g_lat, g_ok);
    m0_addr = 19'h00160;
    e = sb.pop_front();
    checks++; if (g_lat != 5 || g_port !== e.port || g_data !== e.data) begin errors++; $display("FAIL b2b_first got %0d/%h lat %0d want %0d/%h lat 5", g_port, g_data, g_lat, e.port, e.data); end
    wait_any(g_port, g_data, g_lat, g_ok);
    m0_req = 1'b0;
    e = sb.pop_front();
    checks++; if (!g_ok || g_lat != 5) begin errors++; $display("FAIL b2b_interval got %0d want 5", g_lat); end
    checks++; if (g_port !== e.port || g_data !== e.data) begin errors++; $display("FAIL b2b_second got %0d/%h want %0d/%h", g_port, g_data, e.port, e.data); end
  endtask

  initial begin
    test_reset;
    test_m0_read;
    test_m1_write;
    test_strobes;
    test_round_robin;
    test_fixed_prio;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
